// File: rtl/shift_counter_pkg.sv
// Shared mode codes and next-state helper for the shift_counter8 block.
// Imported by the next-state logic, the register top and the bench.
package shift_counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SHL     = 2'b00;
    localparam mode_t MODE_SHR     = 2'b01;
    localparam mode_t MODE_RING    = 2'b10;
    localparam mode_t MODE_JOHNSON = 2'b11;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/shift_counter_next.sv
// Combinational next-state function for shift_counter8.
// Advances q by one step in the mode selected by control.
module shift_counter_next
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            control,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = '0;
        unique case (control)
            MODE_SHL:     next = {q[WIDTH-2:0], 1'b0};
            MODE_SHR:     next = {1'b0, q[WIDTH-1:1]};
            MODE_RING:    next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_JOHNSON: next = {~q[0], q[WIDTH-1:1]};
            default:      next = 'x;
        endcase
    end

endmodule

// File: rtl/shift_counter8.sv
// Parallel-loadable shift register / ring / Johnson counter.
// Priority per edge: rst, then load, then the selected mode step.
module shift_counter8
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             load,
    input  logic [1:0]       control,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_next;

    shift_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .q       (q),
        .control (mode_t'(control)),
        .next    (q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= i;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: tb/tb_shift_counter8.sv
// Directed bench for shift_counter8 with hand-computed expectations.
// Inputs change on the falling edge; q is sampled 1ns after the rising edge.
module tb_shift_counter8;
    import shift_counter_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] i;
    logic       load;
    logic [1:0] control;
    logic [7:0] q;

    int total;
    int bad;

    shift_counter8 #(
        .WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .load    (load),
        .control (control),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h want=%02h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic ld,
                        input logic [7:0] d, input logic [1:0] c);
        @(negedge clk);
        rst     = r;
        load    = ld;
        i       = d;
        control = c;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] jtab [16];

    initial begin
        total = 0;
        bad   = 0;
        rst     = 1'b1;
        load    = 1'b1;
        i       = 8'hFF;
        control = MODE_SHL;

        jtab = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

        // reset beats load
        step(1, 1, 8'hFF, MODE_SHL); chk("rst0", q, 8'h00);
        step(1, 1, 8'hFF, MODE_SHL); chk("rst1", q, 8'h00);
        step(0, 1, 8'hFF, MODE_SHL); chk("rel_load", q, 8'hFF);

        // load and shift left/right
        step(0, 1, 8'h97, MODE_SHL); chk("load97", q, 8'h97);
        step(0, 0, 8'h00, MODE_SHL); chk("shl", q, 8'h2E);
        step(0, 0, 8'h00, MODE_SHR); chk("shr0", q, 8'h17);
        step(0, 0, 8'h00, MODE_SHR); chk("shr1", q, 8'h0B);
        step(0, 0, 8'h00, MODE_SHR); chk("shr2", q, 8'h05);
        step(0, 0, 8'h00, MODE_SHR); chk("shr3", q, 8'h02);
        step(0, 0, 8'h00, MODE_SHR); chk("shr4", q, 8'h01);
        step(0, 0, 8'h00, MODE_SHR); chk("shr5", q, 8'h00);
        step(0, 0, 8'h00, MODE_SHR); chk("shr_zero", q, 8'h00);

        // ring
        step(0, 1, 8'h17, MODE_JOHNSON); chk("load17", q, 8'h17);
        step(0, 0, 8'h00, MODE_RING); chk("ring17", q, 8'h2E);
        step(0, 0, 8'h00, MODE_JOHNSON); chk("john2e", q, 8'h97);
        step(0, 1, 8'h80, MODE_RING); chk("load80", q, 8'h80);
        step(0, 0, 8'h00, MODE_RING); chk("ring_wrap", q, 8'h01);
        step(0, 0, 8'h00, MODE_RING); chk("ring02", q, 8'h02);
        step(0, 0, 8'h00, MODE_SHL); chk("shl04", q, 8'h04);

        // full Johnson cycle from zero
        step(1, 0, 8'h00, MODE_JOHNSON); chk("rst_mid", q, 8'h00);
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 8'h00, MODE_JOHNSON);
            chk($sformatf("john%0d", k + 1), q, jtab[k]);
        end

        // zero holds in shl and ring
        step(0, 0, 8'h00, MODE_SHL);  chk("shl_zero", q, 8'h00);
        step(0, 0, 8'h00, MODE_RING); chk("ring_zero", q, 8'h00);

        // priority
        step(0, 1, 8'h5A, MODE_JOHNSON); chk("load_wins", q, 8'h5A);
        step(1, 1, 8'h33, MODE_RING); chk("rst_wins", q, 8'h00);

        // reset mid-Johnson
        step(0, 0, 8'h00, MODE_JOHNSON); chk("jm1", q, 8'h80);
        step(0, 0, 8'h00, MODE_JOHNSON); chk("jm2", q, 8'hC0);
        step(0, 0, 8'h00, MODE_JOHNSON); chk("jm3", q, 8'hE0);
        step(1, 0, 8'h00, MODE_JOHNSON); chk("jm_rst", q, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
